execute_md: RTL and testbench

- Parametrised execute stage with an output pipeline register, sitting between decode and memory.
- Single-cycle ALU ops issue back-to-back.
- Multiply and divide/remainder run on an internal multi-cycle FSM that stalls upstream until the result is registered.
- Adds a flush input and 32-bit word mode, both with explicit, defined semantics.

---
 rtl/execute_md.sv | 218 +++++++++++++++++++++
 tb/tb_execute_md.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_md.sv
// Execute stage: single-cycle ALU plus a multi-cycle multiply/divide FSM,
// both feeding one registered output toward the memory stage.
module execute_md #(
  parameter int XLEN       = 64,
  parameter int MUL_CYCLES = 4,
  parameter int DST_W      = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [3:0]       in_op,
  input  logic             in_word,
  input  logic [XLEN-1:0]  in_srca,
  input  logic [XLEN-1:0]  in_srcb,
  input  logic [DST_W-1:0] in_dst,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             stall_in,
  output logic             stall_out,
  output logic             out_valid,
  output logic [XLEN-1:0]  out_result,
  output logic [DST_W-1:0] out_dst,
  output logic [XLEN-1:0]  out_pc
);
  localparam int SH_W  = $clog2(XLEN);
  localparam int CNT_W = $clog2((XLEN > MUL_CYCLES) ? XLEN : MUL_CYCLES) + 1;

  localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4,  OP_SLL  = 4'd5,  OP_SRL  = 4'd6,  OP_SRA   = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8,  OP_SLTU = 4'd9,  OP_MUL  = 4'd10, OP_DIV   = 4'd11;
  localparam logic [3:0] OP_DIVU = 4'd12, OP_REM  = 4'd13, OP_REMU = 4'd14, OP_PASSB = 4'd15;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] counter, counter_nx;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic signed [31:0] s;
    s = v;
    return XLEN'(s);
  endfunction

  function automatic logic [XLEN-1:0] alu(input logic [3:0] op, input logic word,
                                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [31:0]     a32, b32;
    logic [4:0]      sh32;
    logic [SH_W-1:0] sh;
    logic [XLEN-1:0] r;
    a32  = a[31:0];
    b32  = b[31:0];
    sh32 = b[4:0];
    sh   = b[SH_W-1:0];
    r    = '0;
    if (word) begin
      case (op)
        OP_ADD:   r = sext32(a32 + b32);
        OP_SUB:   r = sext32(a32 - b32);
        OP_AND:   r = sext32(a32 & b32);
        OP_OR:    r = sext32(a32 | b32);
        OP_XOR:   r = sext32(a32 ^ b32);
        OP_SLL:   r = sext32(a32 << sh32);
        OP_SRL:   r = sext32(a32 >> sh32);
        OP_SRA:   r = sext32($unsigned($signed(a32) >>> sh32));
        OP_SLT:   r = XLEN'($signed(a32) < $signed(b32));
        OP_SLTU:  r = XLEN'(a32 < b32);
        OP_PASSB: r = sext32(b32);
        default:  r = '0;
      endcase
    end else begin
      case (op)
        OP_ADD:   r = a + b;
        OP_SUB:   r = a - b;
        OP_AND:   r = a & b;
        OP_OR:    r = a | b;
        OP_XOR:   r = a ^ b;
        OP_SLL:   r = a << sh;
        OP_SRL:   r = a >> sh;
        OP_SRA:   r = $unsigned($signed(a) >>> sh);
        OP_SLT:   r = XLEN'($signed(a) < $signed(b));
        OP_SLTU:  r = XLEN'(a < b);
        OP_PASSB: r = b;
        default:  r = '0;
      endcase
    end
    return r;
  endfunction

  logic            is_mul, is_div, is_md, md_signed, issue_md;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, quo_init, alu_result;

  assign is_mul    = (in_op == OP_MUL);
  assign is_div    = (in_op == OP_DIV) || (in_op == OP_DIVU) || (in_op == OP_REM) || (in_op == OP_REMU);
  assign is_md     = is_mul || is_div;
  assign md_signed = (in_op == OP_DIV) || (in_op == OP_REM);
  assign issue_md  = (state == IDLE) && in_valid && is_md;
  assign a_ext     = in_word ? (md_signed ? sext32(in_srca[31:0]) : XLEN'(in_srca[31:0])) : in_srca;
  assign b_ext     = in_word ? (md_signed ? sext32(in_srcb[31:0]) : XLEN'(in_srcb[31:0])) : in_srcb;
  assign a_mag     = (md_signed && a_ext[XLEN-1]) ? -a_ext : a_ext;
  assign b_mag     = (md_signed && b_ext[XLEN-1]) ? -b_ext : b_ext;
  // Word divides start with the 32-bit magnitude at the top so 32 steps drain it.
  assign quo_init  = in_word ? (a_mag << (XLEN - 32)) : a_mag;
  assign alu_result = alu(in_op, in_word, in_srca, in_srcb);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      counter <= '0;
    end else if (flush) begin
      state   <= IDLE;
      counter <= '0;
    end else begin
      state   <= state_nx;
      counter <= counter_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    counter_nx = counter;
    case (state)
      IDLE: begin
        if (in_valid && is_mul) begin
          state_nx   = MUL;
          counter_nx = CNT_W'(MUL_CYCLES - 1);
        end else if (in_valid && is_div) begin
          state_nx   = DIV;
          counter_nx = in_word ? CNT_W'(31) : CNT_W'(XLEN - 1);
        end
      end
      MUL, DIV: begin
        if (counter == '0) state_nx = DONE;
        else               counter_nx = counter - 1'b1;
      end
      DONE: if (!stall_in) state_nx = IDLE;
    endcase
  end

  always_comb begin
    stall_out = stall_in || (state == MUL) || (state == DIV) || issue_md;
  end

  // p0: latched mul/div operands and the restoring-divide working registers
  logic [3:0]      op_p0;
  logic            word_p0;
  logic [XLEN-1:0] a_p0, b_p0, quo_p0, rem_p0, dvs_p0;
  logic [XLEN:0]   div_shift;
  logic [XLEN-1:0] div_sub;
  logic            div_fit;

  assign div_shift = {rem_p0, quo_p0[XLEN-1]};
  assign div_fit   = (div_shift >= {1'b0, dvs_p0});
  assign div_sub   = div_shift[XLEN-1:0] - dvs_p0;

  always_ff @(posedge clk) begin
    if (issue_md) begin
      op_p0   <= in_op;
      word_p0 <= in_word;
      a_p0    <= a_ext;
      b_p0    <= b_ext;
      quo_p0  <= quo_init;
      rem_p0  <= '0;
      dvs_p0  <= b_mag;
    end else if (state == DIV) begin
      quo_p0 <= {quo_p0[XLEN-2:0], div_fit};
      rem_p0 <= div_fit ? div_sub : div_shift[XLEN-1:0];
    end
  end

  logic            neg_a, neg_b;
  logic [XLEN-1:0] prod, quo_mag, quo, rem, md_raw, md_result;

  always_comb begin
    neg_a   = ((op_p0 == OP_DIV) || (op_p0 == OP_REM)) && a_p0[XLEN-1];
    neg_b   = ((op_p0 == OP_DIV) || (op_p0 == OP_REM)) && b_p0[XLEN-1];
    prod    = a_p0 * b_p0;
    quo_mag = word_p0 ? XLEN'(quo_p0[31:0]) : quo_p0;
    quo     = (neg_a ^ neg_b) ? -quo_mag : quo_mag;
    rem     = neg_a ? -rem_p0 : rem_p0;
    if (b_p0 == '0) begin
      quo = '1;
      rem = a_p0;
    end
    case (op_p0)
      OP_MUL:          md_raw = prod;
      OP_DIV, OP_DIVU: md_raw = quo;
      default:         md_raw = rem;
    endcase
    md_result = word_p0 ? sext32(md_raw[31:0]) : md_raw;
  end

  // p1: output register toward the memory stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_dst    <= '0;
      out_pc     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (!stall_in) begin
      if (state == DONE) begin
        out_valid  <= 1'b1;
        out_result <= md_result;
        out_dst    <= in_dst;
        out_pc     <= in_pc;
      end else if ((state == IDLE) && in_valid && !is_md) begin
        out_valid  <= 1'b1;
        out_result <= alu_result;
        out_dst    <= in_dst;
        out_pc     <= in_pc;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_execute_md.sv
// Randomized self-checking bench for execute_md against an arithmetic reference model.
module tb_execute_md;
  localparam int XLEN = 64;
  localparam int MC   = 4;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_word, stall_in;
  logic [3:0]  in_op;
  logic [63:0] in_srca, in_srcb, in_pc;
  logic [4:0]  in_dst;
  logic        stall_out, out_valid;
  logic [63:0] out_result, out_pc;
  logic [4:0]  out_dst;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  execute_md #(.XLEN(XLEN), .MUL_CYCLES(MC), .DST_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_op(in_op),
    .in_word(in_word), .in_srca(in_srca), .in_srcb(in_srcb), .in_dst(in_dst),
    .in_pc(in_pc), .stall_in(stall_in), .stall_out(stall_out), .out_valid(out_valid),
    .out_result(out_result), .out_dst(out_dst), .out_pc(out_pc)
  );

  function automatic logic [63:0] ref_model(input logic [3:0] op, input logic word,
                                            input logic [63:0] a, input logic [63:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    int wa, wb, wr;
    int unsigned wua, wub;
    logic ovf32, ovf64;
    logic [63:0] r;
    sa = a; sb = b; ua = a; ub = b;
    wa = a[31:0]; wb = b[31:0]; wua = a[31:0]; wub = b[31:0];
    ovf32 = (a[31:0] == 32'h8000_0000) && (b[31:0] == 32'hFFFF_FFFF);
    ovf64 = (a == 64'h8000_0000_0000_0000) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
    wr = 0;
    r = 64'd0;
    if (word) begin
      case (op)
        0: wr = wa + wb;
        1: wr = wa - wb;
        2: wr = wa & wb;
        3: wr = wa | wb;
        4: wr = wa ^ wb;
        5: wr = wa << b[4:0];
        6: wr = int'(wua >> b[4:0]);
        7: wr = wa >>> b[4:0];
        8: wr = (wa < wb) ? 1 : 0;
        9: wr = (wua < wub) ? 1 : 0;
        10: wr = wa * wb;
        11: if (wb == 0) wr = -1; else if (ovf32) wr = wa; else wr = wa / wb;
        12: if (wub == 0) wr = -1; else wr = int'(wua / wub);
        13: if (wb == 0) wr = wa; else if (ovf32) wr = 0; else wr = wa % wb;
        14: if (wub == 0) wr = wa; else wr = int'(wua % wub);
        default: wr = wb;
      endcase
      r = {{32{wr[31]}}, wr};
    end else begin
      case (op)
        0: r = a + b;
        1: r = a - b;
        2: r = a & b;
        3: r = a | b;
        4: r = a ^ b;
        5: r = a << b[5:0];
        6: r = a >> b[5:0];
        7: r = sa >>> b[5:0];
        8: r = (sa < sb) ? 64'd1 : 64'd0;
        9: r = (ua < ub) ? 64'd1 : 64'd0;
        10: r = a * b;
        11: if (sb == 0) r = '1; else if (ovf64) r = a; else r = sa / sb;
        12: if (ub == 0) r = '1; else r = ua / ub;
        13: if (sb == 0) r = a; else if (ovf64) r = 64'd0; else r = sa % sb;
        14: if (ub == 0) r = a; else r = ua % ub;
        default: r = b;
      endcase
    end
    return r;
  endfunction

  function automatic logic [63:0] rand_val();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'd1;
      2: return 64'hFFFF_FFFF_FFFF_FFFF;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'($urandom_range(0, 40));
      5: return {$urandom, 32'h8000_0000};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic word, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] dst, input logic [63:0] pc);
    in_valid = 1'b1; in_op = op; in_word = word;
    in_srca = a; in_srcb = b; in_dst = dst; in_pc = pc;
  endtask

  // Presents a mul/div and holds it until a result shows up or the budget runs out.
  task automatic run_md(input logic [3:0] op, input logic word, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] dst, input logic [63:0] pc,
                        output int edges);
    drive(op, word, a, b, dst, pc);
    edges = 0;
    while (edges < 200) begin
      step();
      edges++;
      if (out_valid === 1'b1) break;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; stall_in = 1'b0;
    in_valid = 1'b0; in_op = 4'd0; in_word = 1'b0;
    in_srca = '0; in_srcb = '0; in_dst = '0; in_pc = '0;
    #2 reset = 1'b0;
    drive(4'd0, 1'b0, 64'd1, 64'd1, 5'd1, 64'h10);
    step();
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_result !== 64'd0) begin errors++; $display("FAIL reset_result got=%h exp=0", out_result); end
    checks++; if ({out_dst, out_pc} !== '0) begin errors++; $display("FAIL reset_dst_pc got=%h/%h exp=0", out_dst, out_pc); end
    in_valid = 1'b0;
    #1;
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall_out); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_add_sub();
    drive(4'd0, 1'b0, 64'd5, 64'd7, 5'd3, 64'h100);
    step();
    drive(4'd1, 1'b0, 64'd5, 64'd7, 5'd4, 64'h104);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got=%b exp=1", out_valid); end
    checks++; if (out_result !== 64'd12) begin errors++; $display("FAIL add_result got=%h exp=%h", out_result, 64'd12); end
    checks++; if (out_dst !== 5'd3 || out_pc !== 64'h100) begin errors++; $display("FAIL add_dst_pc got=%h/%h exp=3/100", out_dst, out_pc); end
    step();
    in_valid = 1'b0;
    checks++; if (out_result !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL sub_result got=%h exp=fffffffffffffffe", out_result); end
    checks++; if (out_valid !== 1'b1 || out_dst !== 5'd4) begin errors++; $display("FAIL sub_valid_dst got=%b/%h exp=1/4", out_valid, out_dst); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bubble_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_alu_random();
    logic [3:0] op;
    logic       w;
    logic [63:0] a, b, exp, pc;
    logic [4:0]  dst;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 10));
      if (op == 4'd10) op = 4'd15;
      w = 1'($urandom_range(0, 1));
      a = rand_val(); b = rand_val();
      dst = 5'($urandom); pc = {32'd0, $urandom};
      exp = ref_model(op, w, a, b);
      drive(op, w, a, b, dst, pc);
      #1;
      checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL alu_stall op=%0d got=%b exp=0", op, stall_out); end
      step();
      checks++; if (out_valid !== 1'b1 || out_result !== exp) begin errors++; $display("FAIL alu op=%0d w=%b a=%h b=%h got=%b/%h exp=1/%h", op, w, a, b, out_valid, out_result, exp); end
      checks++; if (out_dst !== dst || out_pc !== pc) begin errors++; $display("FAIL alu_dst_pc got=%h/%h exp=%h/%h", out_dst, out_pc, dst, pc); end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_mul_directed();
    drive(4'd10, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFC, 5'd6, 64'h300);
    for (int c = 0; c <= MC; c++) begin
      #1;
      checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL mul_stall cycle=%0d got=%b exp=1", c, stall_out); end
      step();
    end
    #1;
    checks++; if (stall_out !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL mul_done_cycle stall/valid got=%b/%b exp=0/0", stall_out, out_valid); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_result !== 64'hFFFF_FFFF_FFFF_FFF4) begin errors++; $display("FAIL mul_result got=%b/%h exp=1/fffffffffffffff4", out_valid, out_result); end
    checks++; if (out_dst !== 5'd6 || out_pc !== 64'h300) begin errors++; $display("FAIL mul_dst_pc got=%h/%h exp=6/300", out_dst, out_pc); end
    step();
  endtask

  task automatic test_md_random();
    logic [3:0] op;
    logic       w;
    logic [63:0] a, b, exp;
    int edges, lat;
    for (int i = 0; i < 20; i++) begin
      op = (i < 6) ? 4'd10 : 4'($urandom_range(11, 14));
      w  = 1'($urandom_range(0, 1));
      a = rand_val(); b = rand_val();
      exp = ref_model(op, w, a, b);
      lat = (op == 4'd10) ? MC + 2 : (w ? 34 : XLEN + 2);
      run_md(op, w, a, b, 5'(i), 64'(i * 4), edges);
      checks++; if (edges !== lat) begin errors++; $display("FAIL md_latency op=%0d w=%b got=%0d exp=%0d", op, w, edges, lat); end
      checks++; if (out_result !== exp || out_dst !== 5'(i)) begin errors++; $display("FAIL md op=%0d w=%b a=%h b=%h got=%h exp=%h", op, w, a, b, out_result, exp); end
      step();
    end
  endtask

  logic [3:0]  d_op  [4] = '{4'd11, 4'd13, 4'd12, 4'd13};
  logic        d_word[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic [63:0] d_a   [4] = '{64'h8000_0000, 64'h8000_0000, 64'h1234_5678_9ABC_DEF0, 64'd17};
  logic [63:0] d_b   [4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0};
  logic [63:0] d_exp [4] = '{64'hFFFF_FFFF_8000_0000, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd17};
  int          d_lat [4] = '{34, 34, 66, 66};

  task automatic test_div_corner();
    int edges;
    for (int i = 0; i < 4; i++) begin
      run_md(d_op[i], d_word[i], d_a[i], d_b[i], 5'd8, 64'h400, edges);
      checks++; if (edges !== d_lat[i]) begin errors++; $display("FAIL div_corner_latency case=%0d got=%0d exp=%0d", i, edges, d_lat[i]); end
      checks++; if (out_result !== d_exp[i]) begin errors++; $display("FAIL div_corner case=%0d got=%h exp=%h", i, out_result, d_exp[i]); end
      step();
    end
  endtask

  task automatic test_stall_done();
    drive(4'd0, 1'b0, 64'd1, 64'd2, 5'd9, 64'h200);
    step();
    stall_in = 1'b1;
    drive(4'd11, 1'b0, 64'd100, 64'd7, 5'd10, 64'h204);
    repeat (XLEN + 1) step();
    for (int c = 0; c < 10; c++) begin
      checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL done_stall cycle=%0d got=%b exp=1", c, stall_out); end
      checks++; if (out_result !== 64'd3 || out_dst !== 5'd9 || out_pc !== 64'h200) begin errors++; $display("FAIL done_hold cycle=%0d got=%h/%h/%h exp=3/9/200", c, out_result, out_dst, out_pc); end
      step();
    end
    stall_in = 1'b0;
    #1;
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL done_release_stall got=%b exp=0", stall_out); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_result !== 64'd14 || out_dst !== 5'd10) begin errors++; $display("FAIL div_after_stall got=%b/%h/%h exp=1/e/a", out_valid, out_result, out_dst); end
    step();
  endtask

  task automatic test_flush();
    drive(4'd11, 1'b0, 64'd1000, 64'd3, 5'd7, 64'h500);
    repeat (20) step();
    flush = 1'b1;
    in_valid = 1'b0;
    step();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0 || stall_out !== 1'b0) begin errors++; $display("FAIL flush_div valid/stall got=%b/%b exp=0/0", out_valid, stall_out); end
    drive(4'd10, 1'b0, 64'd2, 64'd2, 5'd1, 64'h0);
    #1;
    checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL flush_stall_follow got=%b exp=1", stall_out); end
    drive(4'd0, 1'b0, 64'd1, 64'd1, 5'd2, 64'h504);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop got=%b exp=0", out_valid); end
    for (int c = 0; c < 70; c++) begin
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_late_result cycle=%0d got=%b exp=0", c, out_valid); break; end
    end
    drive(4'd0, 1'b0, 64'd2, 64'd3, 5'd3, 64'h508);
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_result !== 64'd5) begin errors++; $display("FAIL post_flush_add got=%b/%h exp=1/5", out_valid, out_result); end
    step();
  endtask

  task automatic test_async_reset();
    drive(4'd10, 1'b0, 64'd5, 64'd6, 5'd11, 64'h600);
    step();
    step();
    #3;
    reset = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || stall_out !== 1'b0) begin errors++; $display("FAIL async_reset valid/stall got=%b/%b exp=0/0", out_valid, stall_out); end
    checks++; if (out_result !== 64'd0 || out_pc !== 64'd0) begin errors++; $display("FAIL async_reset_data got=%h/%h exp=0/0", out_result, out_pc); end
    step();
    reset = 1'b1;
    drive(4'd5, 1'b0, 64'd1, 64'd63, 5'd12, 64'h700);
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_result !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL sll_after_reset got=%b/%h exp=1/8000000000000000", out_valid, out_result); end
    for (int c = 0; c < 8; c++) begin
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL aborted_mul_result cycle=%0d got=%b exp=0", c, out_valid); break; end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add_sub();
    test_alu_random();
    test_mul_directed();
    test_md_random();
    test_div_corner();
    test_stall_done();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
